approx_avg_host: RTL and testbench

- Host-side sequencer that drives the approximate-averaging 3x3 filter (8-bit sample in X, 10-bit result out Y, 9-sample sliding window).
- On `start`, it:
  - resets the filter,
  - streams LEN samples from a source memory into the filter, one per clock,
  - captures the filter result for every complete window,
  - writes LEN-WIN+1 results to a result memory.
- It sits between the frame/sample buffer and the filter; it is the transmitting end of the filter's X stream and the receiving end of its Y stream.

---
 rtl/approx_avg_host.sv | 145 ++++++++++++++
 tb/tb_approx_avg_host.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_avg_host.sv
// approx_avg_host
//   Host-side sequencer for the approximate-averaging sliding-window filter.
//   On start it resets the filter, streams LEN samples from the source memory
//   into the filter (one per clock, never stalling), and writes the filter
//   result of every complete WIN-sample window to the result memory.
//
// Ports
//   clk, reset        : clock (posedge) and synchronous active-high reset
//   start             : one-cycle job request, sampled only in IDLE
//   busy, done        : job in progress / one-cycle completion pulse
//   src_rd, src_addr  : source read strobe and address
//   src_data          : source data, valid one cycle after src_rd
//   flt_rst           : filter reset (also high while reset is high)
//   x_out             : sample to the filter X input
//   y_in              : filter Y output (filter updates it on negedge)
//   res_wr, res_addr,
//   res_data          : result write strobe, address and data
module approx_avg_host #(
    parameter int DATA_W = 8,
    parameter int RES_W  = 10,
    parameter int WIN    = 9,
    parameter int LEN    = 128,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              src_rd,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic              flt_rst,
    output logic [DATA_W-1:0] x_out,
    input  logic [RES_W-1:0]  y_in,
    output logic              res_wr,
    output logic [ADDR_W-1:0] res_addr,
    output logic [RES_W-1:0]  res_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // One extra counter bit so LEN = 2^ADDR_W is still representable.
    localparam int              CW     = ADDR_W + 1;
    localparam logic [CW-1:0]   LAST   = CW'(LEN - 1);
    localparam logic [ADDR_W-1:0] WIN_M1 = ADDR_W'(WIN - 1);

    logic [2:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_drain;

    // Per-sample tags travelling alongside the data: stage 1 = src_data valid,
    // stage 2 = sample on x_out, stage 3 = y_in holds the window ending here.
    logic              r_v1, r_v2, r_v3;
    logic [ADDR_W-1:0] r_i1, r_i2, r_i3;

    logic [DATA_W-1:0] r_x;
    logic              r_res_wr;
    logic [ADDR_W-1:0] r_res_addr;
    logic [RES_W-1:0]  r_res_data;

    logic              w_rd;
    logic              w_wr_next;

    assign w_rd      = (r_state == S_RUN);
    // Windows ending before sample WIN-1 are partly zero-filled; skip them.
    assign w_wr_next = r_v3 && (r_i3 >= WIN_M1);

    assign busy     = (r_state == S_CLR) || (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);
    assign src_rd   = w_rd;
    assign src_addr = r_cnt[ADDR_W-1:0];
    assign flt_rst  = reset || (r_state == S_CLR);
    assign x_out    = r_x;
    assign res_wr   = r_res_wr;
    assign res_addr = r_res_addr;
    assign res_data = r_res_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_drain    <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_i1       <= '0;
            r_i2       <= '0;
            r_i3       <= '0;
            r_x        <= '0;
            r_res_wr   <= 1'b0;
            r_res_addr <= '0;
            r_res_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_CLR;
                end
                S_CLR: begin
                    r_cnt   <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (r_cnt == LAST) begin
                        r_drain <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 2'd3) r_state <= S_DONE;
                    else                 r_drain <= r_drain + 2'd1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            r_v1 <= w_rd;
            r_i1 <= r_cnt[ADDR_W-1:0];
            r_v2 <= r_v1;
            r_i2 <= r_i1;
            r_v3 <= r_v2;
            r_i3 <= r_i2;

            // x_out is zero whenever no sample is in flight.
            r_x <= r_v1 ? src_data : '0;

            r_res_wr <= w_wr_next;
            if (w_wr_next) begin
                r_res_addr <= r_i3 - WIN_M1;
                r_res_data <= y_in;
            end
        end
    end

endmodule

// File: tb/tb_approx_avg_host.sv
// tb_approx_avg_host
//   Directed bench for approx_avg_host. Two hosts (LEN=16 and LEN=9) each
//   drive a behavioural source memory and a behavioural filter whose Y output
//   is the 9-sample window sum divided by 4, updated on negedge.
module tb_approx_avg_host;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: LEN = 16 ----------------
    logic       a_start, a_busy, a_done, a_src_rd, a_flt_rst, a_res_wr;
    logic [6:0] a_src_addr, a_res_addr;
    logic [7:0] a_src_data = '0;
    logic [7:0] a_x_out;
    logic [9:0] a_y_in = '0;
    logic [9:0] a_res_data;
    logic [7:0] mem_a [0:15];
    logic [71:0] fa = '0;

    approx_avg_host #(.DATA_W(8), .RES_W(10), .WIN(9), .LEN(16), .ADDR_W(7)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
        .src_rd(a_src_rd), .src_addr(a_src_addr), .src_data(a_src_data),
        .flt_rst(a_flt_rst), .x_out(a_x_out), .y_in(a_y_in),
        .res_wr(a_res_wr), .res_addr(a_res_addr), .res_data(a_res_data)
    );

    // ---------------- instance B: LEN = WIN = 9 ----------------
    logic       b_start, b_busy, b_done, b_src_rd, b_flt_rst, b_res_wr;
    logic [6:0] b_src_addr, b_res_addr;
    logic [7:0] b_src_data = '0;
    logic [7:0] b_x_out;
    logic [9:0] b_y_in = '0;
    logic [9:0] b_res_data;
    logic [7:0] mem_b [0:8];
    logic [71:0] fb = '0;

    approx_avg_host #(.DATA_W(8), .RES_W(10), .WIN(9), .LEN(9), .ADDR_W(7)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
        .src_rd(b_src_rd), .src_addr(b_src_addr), .src_data(b_src_data),
        .flt_rst(b_flt_rst), .x_out(b_x_out), .y_in(b_y_in),
        .res_wr(b_res_wr), .res_addr(b_res_addr), .res_data(b_res_data)
    );

    // ---------------- source memories and filters ----------------
    function automatic logic [9:0] favg(input logic [71:0] w);
        int s;
        s = 0;
        for (int k = 0; k < 9; k++) s += int'(w[k*8 +: 8]);
        return 10'(s >> 2);
    endfunction

    always @(posedge clk) if (a_src_rd) a_src_data <= mem_a[a_src_addr[3:0]];
    always @(posedge clk) if (b_src_rd) b_src_data <= mem_b[b_src_addr[3:0] % 9];

    always @(posedge clk) fa <= a_flt_rst ? '0 : {fa[63:0], a_x_out};
    always @(posedge clk) fb <= b_flt_rst ? '0 : {fb[63:0], b_x_out};
    always @(negedge clk) a_y_in <= favg(fa);
    always @(negedge clk) b_y_in <= favg(fb);

    // ---------------- monitors (sampled on negedge) ----------------
    int wa_n = 0, ra_n = 0, da_n = 0, fla_n = 0, da_cyc = 0;
    int wa_addr [0:255];
    int wa_data [0:255];
    int wa_cyc  [0:255];
    int ra_addr [0:255];
    int wb_n = 0, db_n = 0, db_cyc = 0, wb_addr0 = -1, wb_data0 = -1;

    always @(negedge clk) begin
        if (a_res_wr) begin
            wa_addr[wa_n % 256] <= int'(a_res_addr);
            wa_data[wa_n % 256] <= int'(a_res_data);
            wa_cyc[wa_n % 256]  <= cyc;
            wa_n <= wa_n + 1;
        end
        if (a_src_rd) begin
            ra_addr[ra_n % 256] <= int'(a_src_addr);
            ra_n <= ra_n + 1;
        end
        if (a_done) begin
            da_n   <= da_n + 1;
            da_cyc <= cyc;
        end
        if (a_flt_rst) fla_n <= fla_n + 1;
        if (b_res_wr) begin
            if (wb_n == 0) begin
                wb_addr0 <= int'(b_res_addr);
                wb_data0 <= int'(b_res_data);
            end
            wb_n <= wb_n + 1;
        end
        if (b_done) begin
            db_n   <= db_n + 1;
            db_cyc <= cyc;
        end
    end

    // ---------------- helpers ----------------
    int r0, w0, d0, f0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        r0 = ra_n; w0 = wa_n; d0 = da_n; f0 = fla_n;
    endtask

    // Start is presented in the current cycle; s is that (acceptance) cycle.
    task automatic start_a(output int s);
        a_start = 1'b1;
        s = cyc;
        step();
        a_start = 1'b0;
    endtask

    // Checks one complete LEN=16 job. val < 0 selects the ramp source 0..15,
    // whose window ending at i = j+8 sums to 9*j+36.
    task automatic job_a_check(input string nm, input int s, input int val);
        int e;
        chk({nm, "_fltrst_cycles"}, fla_n - f0, 1);
        chk({nm, "_reads"}, ra_n - r0, 16);
        for (int j = 0; j < 16; j++) chk({nm, "_rd_addr"}, ra_addr[(r0 + j) % 256], j);
        chk({nm, "_writes"}, wa_n - w0, 8);
        for (int j = 0; j < 8; j++) begin
            e = (val < 0) ? ((9 * j + 36) >> 2) : val;
            chk({nm, "_wr_addr"}, wa_addr[(w0 + j) % 256], j);
            chk({nm, "_wr_data"}, wa_data[(w0 + j) % 256], e);
            chk({nm, "_wr_cycle"}, wa_cyc[(w0 + j) % 256] - s, 14 + j);
        end
        chk({nm, "_done_pulses"}, da_n - d0, 1);
        chk({nm, "_done_cycle"}, da_cyc - s, 22);
    endtask

    int s1, s2, n;

    initial begin
        reset   = 1'b1;
        a_start = 1'b0;
        b_start = 1'b0;
        for (int i = 0; i < 16; i++) mem_a[i] = 8'd100;
        for (int i = 0; i < 9; i++)  mem_b[i] = 8'(10 * (i + 1));
        repeat (3) step();

        // Reset state
        chk("rst_fltrst_high", a_flt_rst, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_src_rd", a_src_rd, 0);
        chk("rst_res_wr", a_res_wr, 0);
        chk("rst_src_addr", a_src_addr, 0);
        chk("rst_res_addr", a_res_addr, 0);
        chk("rst_x_out", a_x_out, 0);
        chk("rst_res_data", a_res_data, 0);
        reset = 1'b0;
        step();
        chk("idle_fltrst_low", a_flt_rst, 0);
        chk("idle_busy", a_busy, 0);

        // Job 1: constant 100 -> 900/4 = 225
        snap();
        start_a(s1);
        chk("busy_after_start", a_busy, 1);
        chk("fltrst_in_clr", a_flt_rst, 1);
        repeat (25) step();
        job_a_check("const100", s1, 225);
        chk("idle_after_job", a_busy, 0);

        // Job 2: ramp 0..15
        for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
        snap();
        start_a(s1);
        repeat (25) step();
        job_a_check("ramp", s1, -1);

        // Back-to-back: zeros, then 200s started in the IDLE cycle after done
        for (int i = 0; i < 16; i++) mem_a[i] = 8'd0;
        snap();
        start_a(s1);
        n = 0;
        while (a_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("b2b_done_seen", a_done, 1);
        job_a_check("zeros", s1, 0);
        snap();
        for (int i = 0; i < 16; i++) mem_a[i] = 8'd200;
        a_start = 1'b1;          // DONE cycle: must be ignored
        step();
        s2 = cyc;                // following IDLE cycle: accepted
        step();
        a_start = 1'b0;
        repeat (25) step();
        job_a_check("const200", s2, 450);

        // Reset during RUN after 5 reads
        for (int i = 0; i < 16; i++) mem_a[i] = 8'd100;
        snap();
        start_a(s1);
        repeat (5) step();
        reset = 1'b1;
        step();
        chk("abort_busy", a_busy, 0);
        chk("abort_src_rd", a_src_rd, 0);
        chk("abort_res_wr", a_res_wr, 0);
        chk("abort_fltrst", a_flt_rst, 1);
        reset = 1'b0;
        repeat (6) step();
        chk("abort_reads", ra_n - r0, 5);
        chk("abort_writes", wa_n - w0, 0);
        chk("abort_done", da_n - d0, 0);
        for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
        snap();
        start_a(s1);
        repeat (25) step();
        job_a_check("post_abort", s1, -1);

        // start pulsed repeatedly while busy
        for (int i = 0; i < 16; i++) mem_a[i] = 8'd100;
        snap();
        start_a(s1);
        for (int j = 1; j <= 21; j++) begin
            a_start = (j % 2 == 1);
            step();
        end
        a_start = 1'b0;
        repeat (8) step();
        job_a_check("spam", s1, 225);
        chk("spam_idle", a_busy, 0);

        // LEN = WIN = 9: single window 10..90 -> 450/4 = 112
        b_start = 1'b1;
        s1 = cyc;
        step();
        b_start = 1'b0;
        repeat (20) step();
        chk("len9_writes", wb_n, 1);
        chk("len9_addr", wb_addr0, 0);
        chk("len9_data", wb_data0, 112);
        chk("len9_done_pulses", db_n, 1);
        chk("len9_done_cycle", db_cyc - s1, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
